// File: rtl/wbxbc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wbxbc_pkg
// Description : Shared definitions for the round-robin Wishbone arbiter:
//               arbiter state encoding and a constant-evaluable clog2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package wbxbc_pkg;

    typedef enum logic [0:0] {
        STATE_IDLE = 1'b0,
        STATE_BUSY = 1'b1
    } state_t;

    // Ceiling log2, never below 1 so that index/counter vectors keep a width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wbxbc_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : wbxbc_rr_pick
// Description : Combinational round-robin priority picker. Scans the request
//               vector starting one position above the last owner, wrapping,
//               and returns a one-hot grant for the first requester found.
// Ports       : i_req  - request vector, one bit per initiator
//               i_last - index of the previous owner (lowest priority now)
//               o_gnt  - one-hot grant, all zero when nothing is requested
// Revision    : 1.0 - initial release
// ============================================================================
module wbxbc_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_gnt
);

    int   w_idx;
    logic w_found;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        // Offsets 1..N visit every initiator once, the last owner at the end.
        for (int i = 1; i <= N; i++) begin
            w_idx = int'(i_last) + i;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!w_found && i_req[IW'(w_idx)]) begin
                o_gnt[IW'(w_idx)] = 1'b1;
                w_found           = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wbxbc_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : wbxbc_arb_rr
// Description : Round-robin arbiter sharing one pipelined Wishbone target
//               among ITR_CNT pipelined Wishbone initiators. The grant is held
//               for a whole bus cycle (CYC, extended by LOCK), outstanding
//               accepted requests are counted and throttled at MAX_OUT, and
//               responses are returned to the granted initiator only.
// Ports       : clk_i / async_rst_i        - clock, async active-low reset
//               itr_*_i                     - packed per-initiator requests
//               itr_ack/err/rty/stall_o     - per-initiator responses
//               itr_dat_o / itr_tgd_o       - broadcast read data and tag
//               tgt_*_o                     - muxed request to the target
//               tgt_*_i                     - target responses
// Revision    : 1.0 - initial release
// ============================================================================
module wbxbc_arb_rr
    import wbxbc_pkg::*;
#(
    parameter int ITR_CNT    = 4,
    parameter int ADR_WIDTH  = 16,
    parameter int DAT_WIDTH  = 16,
    parameter int SEL_WIDTH  = 2,
    parameter int TGA_WIDTH  = 1,
    parameter int TGC_WIDTH  = 1,
    parameter int TGRD_WIDTH = 1,
    parameter int TGWD_WIDTH = 1,
    parameter int MAX_OUT    = 4
) (
    input  logic                            clk_i,
    input  logic                            async_rst_i,
    input  logic [ITR_CNT-1:0]              itr_cyc_i,
    input  logic [ITR_CNT-1:0]              itr_stb_i,
    input  logic [ITR_CNT-1:0]              itr_we_i,
    input  logic [ITR_CNT-1:0]              itr_lock_i,
    input  logic [ITR_CNT*SEL_WIDTH-1:0]    itr_sel_i,
    input  logic [ITR_CNT*ADR_WIDTH-1:0]    itr_adr_i,
    input  logic [ITR_CNT*DAT_WIDTH-1:0]    itr_dat_i,
    input  logic [ITR_CNT*TGA_WIDTH-1:0]    itr_tga_i,
    input  logic [ITR_CNT*TGC_WIDTH-1:0]    itr_tgc_i,
    input  logic [ITR_CNT*TGWD_WIDTH-1:0]   itr_tgd_i,
    output logic [ITR_CNT-1:0]              itr_ack_o,
    output logic [ITR_CNT-1:0]              itr_err_o,
    output logic [ITR_CNT-1:0]              itr_rty_o,
    output logic [ITR_CNT-1:0]              itr_stall_o,
    output logic [DAT_WIDTH-1:0]            itr_dat_o,
    output logic [TGRD_WIDTH-1:0]           itr_tgd_o,
    output logic                            tgt_cyc_o,
    output logic                            tgt_stb_o,
    output logic                            tgt_we_o,
    output logic                            tgt_lock_o,
    output logic [SEL_WIDTH-1:0]            tgt_sel_o,
    output logic [ADR_WIDTH-1:0]            tgt_adr_o,
    output logic [DAT_WIDTH-1:0]            tgt_dat_o,
    output logic [TGA_WIDTH-1:0]            tgt_tga_o,
    output logic [TGC_WIDTH-1:0]            tgt_tgc_o,
    output logic [TGWD_WIDTH-1:0]           tgt_tgd_o,
    input  logic                            tgt_ack_i,
    input  logic                            tgt_err_i,
    input  logic                            tgt_rty_i,
    input  logic                            tgt_stall_i,
    input  logic [DAT_WIDTH-1:0]            tgt_dat_i,
    input  logic [TGRD_WIDTH-1:0]           tgt_tgd_i
);

    localparam int IW = clog2(ITR_CNT);
    localparam int CW = clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] C_MAX_OUT = CW'(MAX_OUT);

    state_t              r_state;
    logic [ITR_CNT-1:0]  r_gnt;
    logic [IW-1:0]       r_last;
    logic [CW-1:0]       r_cnt;

    logic [ITR_CNT-1:0]  w_pick;
    logic [IW-1:0]       w_gidx;
    logic                w_busy;
    logic                w_cyc;
    logic                w_stb;
    logic                w_we;
    logic                w_lock;
    logic [SEL_WIDTH-1:0]  w_sel;
    logic [ADR_WIDTH-1:0]  w_adr;
    logic [DAT_WIDTH-1:0]  w_dat;
    logic [TGA_WIDTH-1:0]  w_tga;
    logic [TGC_WIDTH-1:0]  w_tgc;
    logic [TGWD_WIDTH-1:0] w_tgd;
    logic                w_full;
    logic                w_acc;
    logic                w_rsp;
    logic                w_release;

    wbxbc_rr_pick #(
        .N  (ITR_CNT),
        .IW (IW)
    ) u_pick (
        .i_req  (itr_cyc_i),
        .i_last (r_last),
        .o_gnt  (w_pick)
    );

    // One-hot AND-OR selection of the granted slice; r_gnt is zero in IDLE,
    // which makes every selected field zero there as well.
    always_comb begin
        w_gidx = '0;
        w_cyc  = 1'b0;
        w_stb  = 1'b0;
        w_we   = 1'b0;
        w_lock = 1'b0;
        w_sel  = '0;
        w_adr  = '0;
        w_dat  = '0;
        w_tga  = '0;
        w_tgc  = '0;
        w_tgd  = '0;
        for (int i = 0; i < ITR_CNT; i++) begin
            if (r_gnt[i]) begin
                w_gidx = IW'(i);
                w_cyc  = itr_cyc_i[i];
                w_stb  = itr_stb_i[i];
                w_we   = itr_we_i[i];
                w_lock = itr_lock_i[i];
                w_sel  = itr_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
                w_adr  = itr_adr_i[i*ADR_WIDTH +: ADR_WIDTH];
                w_dat  = itr_dat_i[i*DAT_WIDTH +: DAT_WIDTH];
                w_tga  = itr_tga_i[i*TGA_WIDTH +: TGA_WIDTH];
                w_tgc  = itr_tgc_i[i*TGC_WIDTH +: TGC_WIDTH];
                w_tgd  = itr_tgd_i[i*TGWD_WIDTH +: TGWD_WIDTH];
            end
        end
    end

    assign w_busy    = (r_state == STATE_BUSY);
    assign w_full    = (r_cnt == C_MAX_OUT);

    assign tgt_cyc_o  = w_busy & w_cyc;
    assign tgt_stb_o  = w_busy & w_stb & ~w_full;
    assign tgt_lock_o = w_busy & w_lock;
    assign tgt_we_o   = w_we;
    assign tgt_sel_o  = w_sel;
    assign tgt_adr_o  = w_adr;
    assign tgt_dat_o  = w_dat;
    assign tgt_tga_o  = w_tga;
    assign tgt_tgc_o  = w_tgc;
    assign tgt_tgd_o  = w_tgd;

    assign itr_dat_o  = tgt_dat_i;
    assign itr_tgd_o  = tgt_tgd_i;

    // Responses only reach the owner, and only while its cycle is open so
    // that late responses after an abort are swallowed.
    assign itr_ack_o  = r_gnt & {ITR_CNT{tgt_ack_i & tgt_cyc_o}};
    assign itr_err_o  = r_gnt & {ITR_CNT{tgt_err_i & tgt_cyc_o}};
    assign itr_rty_o  = r_gnt & {ITR_CNT{tgt_rty_i & tgt_cyc_o}};

    always_comb begin
        itr_stall_o = '1;
        if (w_busy) begin
            itr_stall_o = ~r_gnt | {ITR_CNT{tgt_stall_i | w_full}};
        end
    end

    assign w_acc     = tgt_cyc_o & tgt_stb_o & ~tgt_stall_i;
    assign w_rsp     = tgt_ack_i | tgt_err_i | tgt_rty_i;
    assign w_release = w_busy & ~w_cyc & ~w_lock;

    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            r_state <= STATE_IDLE;
            r_gnt   <= '0;
            r_last  <= IW'(ITR_CNT - 1);
            r_cnt   <= '0;
        end else begin
            case (r_state)
                STATE_IDLE: begin
                    r_cnt <= '0;
                    if (|itr_cyc_i) begin
                        r_gnt   <= w_pick;
                        r_state <= STATE_BUSY;
                    end
                end
                STATE_BUSY: begin
                    if (w_release) begin
                        // Anything still outstanding is abandoned here.
                        r_state <= STATE_IDLE;
                        r_gnt   <= '0;
                        r_last  <= w_gidx;
                        r_cnt   <= '0;
                    end else if (w_acc && !w_rsp) begin
                        r_cnt <= r_cnt + CW'(1);
                    end else if (!w_acc && w_rsp && (r_cnt != '0)) begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= STATE_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
